pause_dimmer: RTL and testbench
===============================

PAUSE_DIMMER -- requirements
Module: pause_dimmer

Interface
REQ-001 Parameter NSRC, default 2: number of external pause-request inputs (e.g. hiscore access, debugger).
REQ-002 Parameter R_W / G_W / B_W, default 3 / 3 / 2: per-channel colour widths, each 1..8.
REQ-003 Parameter DIM_CYCLES, default 240000000: clk_sys cycles of user pause before dimming starts (10 s at 24 MHz).
REQ-004 Parameter FADE_STEPS, default 2: number of dim levels, 1..7.
REQ-005 Parameter FADE_CYCLES, default 1200000: clk_sys cycles between successive dim levels.
REQ-006 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 pause_btn  in  1  user pause button, already synchronous to clk_sys, active-high.
REQ-009 osd_open  in  1  OSD visible.
REQ-010 osd_pause_en  in  1  pause while the OSD is open.
REQ-011 pause_req  in  NSRC  external pause requests, active-high.
REQ-012 ce_pix  in  1  pixel clock enable.
REQ-013 rgb_in  in  R_W+G_W+B_W  pixel, packed {R,G,B}.
REQ-014 hs_in, vs_in, hbl_in, vbl_in  in  1 each  syncs and blanks.
REQ-015 rgb_out  out  R_W+G_W+B_W  dimmed pixel.
REQ-016 hs_out, vs_out, hbl_out, vbl_out  out  1 each  syncs and blanks, delay-matched to rgb_out.
REQ-017 pause  out  1  core pause, active-high.
REQ-018 user_paused  out  1  user toggle state.
REQ-019 dim_level  out  3  current dim level, 0..FADE_STEPS.

Function
REQ-020 A rising edge on pause_btn (previous-cycle sample 0, current 1) SHALL invert user_paused in the following cycle; a held button SHALL NOT retoggle.
REQ-021 pause SHALL be combinational: user_paused | (|pause_req) | (osd_open & osd_pause_en).
REQ-022 The dim FSM SHALL have three states, RUN, WAIT and FADE, and SHALL be in RUN while user_paused=0.
REQ-023 RUN->WAIT SHALL occur on the cycle user_paused becomes 1, and the wait counter SHALL clear to 0.
REQ-024 In WAIT the counter SHALL increment every cycle; at count DIM_CYCLES-1 the FSM SHALL enter FADE with dim_level=1 and the fade counter cleared.
REQ-025 In FADE, dim_level SHALL increment every FADE_CYCLES cycles and SHALL saturate at FADE_STEPS; the counters SHALL NOT wrap.
REQ-026 From WAIT or FADE, user_paused=0 SHALL return the FSM to RUN with dim_level=0 and both counters cleared in the same edge.
REQ-027 External requests and the OSD SHALL assert pause but SHALL NOT start or advance dimming.
REQ-028 Video path: on each clk_sys edge with ce_pix=1, each channel SHALL be registered as channel >> dim_level, shift clamped to the channel width so the result is 0; syncs and blanks SHALL be registered in the same enable.
REQ-029 Video latency SHALL be exactly one ce_pix-qualified clock; with ce_pix=0 all video outputs SHALL hold.
REQ-030 A dim_level change SHALL take effect on the next ce_pix pixel and SHALL NOT tear partially across channels.

Reset
REQ-031 With reset_n low: user_paused=0, FSM=RUN, dim_level=0, counters=0, edge register=0, rgb_out=0, hs_out=vs_out=0, hbl_out=vbl_out=1.
REQ-032 Reset SHALL abort a fade immediately.
REQ-033 pause SHALL still reflect pause_req and OSD terms during reset.

Structure
REQ-034 The FSM state enum and the dim-level width constant SHALL live in the shared package pause_pkg.
REQ-035 Per-channel shifting SHALL be one sub-module, dim_shift, instantiated three times with a width parameter.
REQ-036 Counter widths SHALL derive from $clog2 of DIM_CYCLES and FADE_CYCLES.

Verification
REQ-037 Bench 1: run with DIM_CYCLES=8, FADE_CYCLES=4, FADE_STEPS=2; pulse pause_btn. Required: user_paused=1 next cycle; dim_level=1 eight cycles later; dim_level=2 after four more; dim_level stays 2 thereafter.
REQ-038 Bench 2: hold pause_btn for 20 cycles. Required: exactly one toggle.
REQ-039 Bench 3: apply rgb_in=8'hFF with R_W=3, G_W=3, B_W=2. Required: at level 1, rgb_out={3'd3,3'd3,2'd1}; at level 2, {3'd1,3'd1,2'd0}.
REQ-040 Bench 4: at dim_level=2, press pause_btn. Required: the next cycle gives user_paused=0, FSM=RUN, dim_level=0; the following ce_pix gives an undimmed pixel.
REQ-041 Bench 5: pause_req=2'b01 with osd_open=1 and osd_pause_en=0. Required: pause=1 and dim_level stays 0 indefinitely; with pause_req=0 and osd_pause_en=1, pause=1.
REQ-042 Bench 6: assert reset_n low during FADE. Required: all REQ-031 values hold asynchronously and the block resumes in RUN after release.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared types and constants for the pause/dimmer block.
package pause_pkg;

    localparam int DIM_W = 3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FADE = 2'd2
    } dim_state_e;

    // Counter width for a modulus of n; a modulus of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dim_shift.sv
// One colour channel shifted right by the dim level, forced to 0 once the shift covers the channel.
module dim_shift
    import pause_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0]     din,
    input  logic [DIM_W-1:0] shift,
    output logic [W-1:0]     dout
);

    always_comb begin
        dout = '0;
        if (int'(shift) < W) begin
            dout = din >> shift;
        end
    end

endmodule

// File: rtl/pause_dimmer.sv
// Pause control with a user toggle, plus a screen dimmer that fades the picture
// after the user has held the core paused for a while.
module pause_dimmer
    import pause_pkg::*;
#(
    parameter int NSRC        = 2,
    parameter int R_W         = 3,
    parameter int G_W         = 3,
    parameter int B_W         = 2,
    parameter int DIM_CYCLES  = 240000000,
    parameter int FADE_STEPS  = 2,
    parameter int FADE_CYCLES = 1200000
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     pause_btn,
    input  logic                     osd_open,
    input  logic                     osd_pause_en,
    input  logic [NSRC-1:0]          pause_req,
    input  logic                     ce_pix,
    input  logic [R_W+G_W+B_W-1:0]   rgb_in,
    input  logic                     hs_in,
    input  logic                     vs_in,
    input  logic                     hbl_in,
    input  logic                     vbl_in,
    output logic [R_W+G_W+B_W-1:0]   rgb_out,
    output logic                     hs_out,
    output logic                     vs_out,
    output logic                     hbl_out,
    output logic                     vbl_out,
    output logic                     pause,
    output logic                     user_paused,
    output logic [DIM_W-1:0]         dim_level,
    output dim_state_e               fsm_state
);

    localparam int RGB_W  = R_W + G_W + B_W;
    localparam int WAIT_W = cnt_w(DIM_CYCLES);
    localparam int FADE_W = cnt_w(FADE_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIM_CYCLES - 1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_CYCLES - 1);
    localparam logic [DIM_W-1:0]  LVL_MAX   = DIM_W'(FADE_STEPS);

    logic              btn_q;
    logic              btn_rise;
    logic              user_paused_d;
    dim_state_e        state, state_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic [FADE_W-1:0] fade_cnt, fade_d;
    logic [DIM_W-1:0]  level_d;

    // The FSM follows the toggled value so dimming starts and stops on the same edge as the toggle.
    assign btn_rise      = pause_btn & ~btn_q;
    assign user_paused_d = user_paused ^ btn_rise;

    assign pause     = user_paused | (|pause_req) | (osd_open & osd_pause_en);
    assign fsm_state = state;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q       <= 1'b0;
            user_paused <= 1'b0;
            state       <= ST_RUN;
            wait_cnt    <= '0;
            fade_cnt    <= '0;
            dim_level   <= '0;
        end else begin
            btn_q       <= pause_btn;
            user_paused <= user_paused_d;
            state       <= state_d;
            wait_cnt    <= wait_d;
            fade_cnt    <= fade_d;
            dim_level   <= level_d;
        end
    end

    always_comb begin
        state_d = state;
        wait_d  = wait_cnt;
        fade_d  = fade_cnt;
        level_d = dim_level;
        case (state)
            ST_RUN: begin
                wait_d  = '0;
                fade_d  = '0;
                level_d = '0;
                if (user_paused_d) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!user_paused_d) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                    fade_d  = '0;
                    level_d = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = ST_FADE;
                    fade_d  = '0;
                    level_d = DIM_W'(1);
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            ST_FADE: begin
                if (!user_paused_d) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                    fade_d  = '0;
                    level_d = '0;
                end else if (dim_level < LVL_MAX) begin
                    // Once saturated the fade counter simply holds.
                    if (fade_cnt == FADE_LAST) begin
                        fade_d  = '0;
                        level_d = dim_level + 1'b1;
                    end else begin
                        fade_d = fade_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
                fade_d  = '0;
                level_d = '0;
            end
        endcase
    end

    logic [R_W-1:0] r_dim;
    logic [G_W-1:0] g_dim;
    logic [B_W-1:0] b_dim;

    dim_shift #(.W(R_W)) u_shift_r (
        .din   (rgb_in[RGB_W-1 -: R_W]),
        .shift (dim_level),
        .dout  (r_dim)
    );

    dim_shift #(.W(G_W)) u_shift_g (
        .din   (rgb_in[G_W+B_W-1 -: G_W]),
        .shift (dim_level),
        .dout  (g_dim)
    );

    dim_shift #(.W(B_W)) u_shift_b (
        .din   (rgb_in[B_W-1:0]),
        .shift (dim_level),
        .dout  (b_dim)
    );

    // ce_pix qualifies a pixel: one register stage per enabled edge, everything holds otherwise.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out <= '0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            hbl_out <= 1'b1;
            vbl_out <= 1'b1;
        end else if (ce_pix) begin
            rgb_out <= {r_dim, g_dim, b_dim};
            hs_out  <= hs_in;
            vs_out  <= vs_in;
            hbl_out <= hbl_in;
            vbl_out <= vbl_in;
        end
    end

endmodule

// File: tb/tb_pause_dimmer.sv
// Randomized bench for pause_dimmer: a reference model derives the dim level from elapsed
// pause time, pushes expected pixels to a queue, and a negedge monitor compares.
module tb_pause_dimmer;
    import pause_pkg::*;

    localparam int NSRC  = 2;
    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;
    localparam int DIM   = 8;
    localparam int FC    = 4;
    localparam int FS    = 2;
    localparam logic [RGB_W+3:0] VID_RST = {{RGB_W{1'b0}}, 4'b0011};

    logic             clk_sys = 1'b0;
    logic             reset_n;
    logic             pause_btn, osd_open, osd_pause_en, ce_pix;
    logic [NSRC-1:0]  pause_req;
    logic [RGB_W-1:0] rgb_in, rgb_out;
    logic             hs_in, vs_in, hbl_in, vbl_in;
    logic             hs_out, vs_out, hbl_out, vbl_out;
    logic             pause, user_paused;
    logic [DIM_W-1:0] dim_level;
    dim_state_e       fsm_state;

    pause_dimmer #(
        .NSRC(NSRC), .R_W(R_W), .G_W(G_W), .B_W(B_W),
        .DIM_CYCLES(DIM), .FADE_STEPS(FS), .FADE_CYCLES(FC)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .pause_btn(pause_btn),
        .osd_open(osd_open), .osd_pause_en(osd_pause_en), .pause_req(pause_req),
        .ce_pix(ce_pix), .rgb_in(rgb_in), .hs_in(hs_in), .vs_in(vs_in),
        .hbl_in(hbl_in), .vbl_in(vbl_in), .rgb_out(rgb_out), .hs_out(hs_out),
        .vs_out(vs_out), .hbl_out(hbl_out), .vbl_out(vbl_out), .pause(pause),
        .user_paused(user_paused), .dim_level(dim_level), .fsm_state(fsm_state)
    );

    // clock / watchdog
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected finish before it");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int n_tests = 0;
    int n_fail  = 0;
    logic [RGB_W+3:0] exp_q[$];
    bit   mon_en = 1'b0;

    // reference model state
    int               cyc = 0;
    int               t0 = 0;
    bit               up_m = 1'b0;
    bit               btn_prev_m = 1'b0;
    int               lvl_m = 0;
    logic [RGB_W+3:0] vid_m = VID_RST;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lvl_of(input int e);
        int l;
        if (e < DIM) return 0;
        l = 1 + (e - DIM) / FC;
        return (l > FS) ? FS : l;
    endfunction

    function automatic logic [RGB_W-1:0] dim_pix(input logic [RGB_W-1:0] p, input int l);
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
        r = p[RGB_W-1 -: R_W] >> l;
        g = p[G_W+B_W-1 -: G_W] >> l;
        b = p[B_W-1:0] >> l;
        return {r, g, b};
    endfunction

    function automatic dim_state_e state_of();
        if (!up_m) return ST_RUN;
        return ((cyc - t0) < DIM) ? ST_WAIT : ST_FADE;
    endfunction

    task automatic model_reset();
        up_m       = 1'b0;
        btn_prev_m = 1'b0;
        lvl_m      = 0;
        t0         = cyc;
        vid_m      = VID_RST;
        exp_q.delete();
    endtask

    // Applies one clock edge to the model using the inputs that were present at that edge.
    task automatic model_step();
        logic [RGB_W+3:0] e;
        cyc++;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (ce_pix) begin
            e = {dim_pix(rgb_in, lvl_m), hs_in, vs_in, hbl_in, vbl_in};
            exp_q.push_back(e);
            vid_m = e;
        end
        if (pause_btn && !btn_prev_m) begin
            up_m = !up_m;
            t0   = cyc;
        end
        btn_prev_m = pause_btn;
        lvl_m = up_m ? lvl_of(cyc - t0) : 0;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        model_step();
    endtask

    // monitor
    always @(negedge clk_sys) begin
        logic [RGB_W+3:0] e;
        if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = vid_m;
            check("mon_video", 32'({rgb_out, hs_out, vs_out, hbl_out, vbl_out}), 32'(e));
            check("mon_user_paused", 32'(user_paused), 32'(up_m));
            check("mon_dim_level", 32'(dim_level), 32'(lvl_m));
            check("mon_fsm_state", 32'(fsm_state), 32'(state_of()));
            check("mon_pause", 32'(pause),
                  32'(up_m | (|pause_req) | (osd_open & osd_pause_en)));
        end
    end

    // driver
    initial begin
        reset_n = 1'b1; pause_btn = 1'b0; osd_open = 1'b0; osd_pause_en = 1'b0;
        pause_req = '0; ce_pix = 1'b0; rgb_in = '0;
        hs_in = 1'b0; vs_in = 1'b0; hbl_in = 1'b0; vbl_in = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_user_paused", 32'(user_paused), 32'd0);
        check("rst_dim_level", 32'(dim_level), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_RUN));
        check("rst_video", 32'({rgb_out, hs_out, vs_out, hbl_out, vbl_out}), 32'(VID_RST));
        repeat (3) tick();
        @(negedge clk_sys);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        // pause pulse, fade timing, and dimmed full-scale pixel
        ce_pix = 1'b1; rgb_in = 8'hFF;
        pause_btn = 1'b1;
        tick();
        pause_btn = 1'b0;
        check("b1_toggle", 32'(user_paused), 32'd1);
        repeat (7) tick();
        check("b1_pre_dim", 32'(dim_level), 32'd0);
        tick();
        check("b1_level1", 32'(dim_level), 32'd1);
        tick();
        check("b3_pix_level1", 32'(rgb_out), 32'h6D);
        repeat (2) tick();
        check("b1_level1_hold", 32'(dim_level), 32'd1);
        tick();
        check("b1_level2", 32'(dim_level), 32'd2);
        tick();
        check("b3_pix_level2", 32'(rgb_out), 32'h24);
        repeat (10) tick();
        check("b1_saturate", 32'(dim_level), 32'd2);

        // unpause from full fade
        pause_btn = 1'b1;
        tick();
        pause_btn = 1'b0;
        check("b4_user_paused", 32'(user_paused), 32'd0);
        check("b4_state", 32'(fsm_state), 32'(ST_RUN));
        check("b4_level", 32'(dim_level), 32'd0);
        tick();
        check("b4_undimmed", 32'(rgb_out), 32'hFF);

        // held button toggles once
        pause_btn = 1'b1;
        repeat (20) tick();
        check("b2_single_toggle", 32'(user_paused), 32'd1);
        pause_btn = 1'b0;
        repeat (5) tick();
        check("b2_still_paused", 32'(user_paused), 32'd1);
        pause_btn = 1'b1;
        tick();
        pause_btn = 1'b0;
        check("b2_unpaused", 32'(user_paused), 32'd0);

        // external and OSD pause never dim
        pause_req = 2'b01; osd_open = 1'b1; osd_pause_en = 1'b0;
        repeat (40) tick();
        check("b5_req_pause", 32'(pause), 32'd1);
        check("b5_req_no_dim", 32'(dim_level), 32'd0);
        pause_req = 2'b00; osd_pause_en = 1'b1;
        repeat (30) tick();
        check("b5_osd_pause", 32'(pause), 32'd1);
        check("b5_osd_no_dim", 32'(dim_level), 32'd0);
        osd_open = 1'b0; osd_pause_en = 1'b0;
        tick();
        check("b5_no_pause", 32'(pause), 32'd0);

        // reset in the middle of a fade
        pause_btn = 1'b1;
        tick();
        pause_btn = 1'b0;
        repeat (10) tick();
        check("b6_in_fade", 32'(fsm_state), 32'(ST_FADE));
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        pause_req = 2'b10;
        model_reset();
        #1;
        check("b6_rst_user_paused", 32'(user_paused), 32'd0);
        check("b6_rst_level", 32'(dim_level), 32'd0);
        check("b6_rst_state", 32'(fsm_state), 32'(ST_RUN));
        check("b6_rst_video", 32'({rgb_out, hs_out, vs_out, hbl_out, vbl_out}), 32'(VID_RST));
        check("b6_rst_pause_req", 32'(pause), 32'd1);
        repeat (2) tick();
        @(negedge clk_sys);
        #1;
        reset_n = 1'b1;
        pause_req = 2'b00;
        tick();
        check("b6_resume_state", 32'(fsm_state), 32'(ST_RUN));
        check("b6_resume_user_paused", 32'(user_paused), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            pause_btn    = ($urandom_range(0, 39) == 0) ? ~pause_btn : (pause_btn & ($urandom_range(0, 3) != 0));
            ce_pix       = 1'($urandom_range(0, 1));
            rgb_in       = RGB_W'($urandom);
            hs_in        = 1'($urandom);
            vs_in        = 1'($urandom);
            hbl_in       = 1'($urandom);
            vbl_in       = 1'($urandom);
            pause_req    = ($urandom_range(0, 9) == 0) ? NSRC'($urandom) : '0;
            osd_open     = ($urandom_range(0, 7) == 0);
            osd_pause_en = 1'($urandom);
        end
        tick();
        @(negedge clk_sys);
        #1;
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
